ysyx_220053_rf_wb_arbiter: RTL and testbench
============================================

# ysyx_220053_rf_wb_arbiter

Write-port controller for the core's 2R1W register file. It shares the single write port between two writeback requesters (req0: ALU/CSR path, req1: load path) using round-robin arbitration and drives the register file write port from a registered stage. It also keeps a busy scoreboard, so issue logic can stall on a pending destination and readers can tell when an operand is stale.

## Interface
Parameters:
- ADDR_WIDTH, default 5, register index width; the file holds 2^ADDR_WIDTH entries.
- DATA_WIDTH, default 64, register data width.

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; clears the scoreboard and kills the output stage.
- req0_valid  in  1  requester 0 has a writeback.
- req0_addr  in  ADDR_WIDTH  requester 0 destination index.
- req0_data  in  DATA_WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 writeback accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as req0, for requester 1.
- issue_valid  in  1  issue stage allocates destination issue_addr.
- issue_addr  in  ADDR_WIDTH  destination being allocated.
- issue_ready  out  1  allocation accepted.
- qa_addr, qb_addr  in  ADDR_WIDTH  operand indices (the same values as the register file raaddr/rbaddr).
- qa_busy, qb_busy  out  1  operand has a pending write.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write index.
- rf_wdata  out  DATA_WIDTH  register file write data.

## Operation
- **Arbitration** (combinational):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not granted last.
  - last_grant register resets to 1, so req0 wins the first contention.
  - reqN_ready = grant to N. It is never asserted without reqN_valid. At most one ready per cycle.
  - last_grant updates only when a grant occurs.
- **Output stage** (registered):
  - On a grant, the stage loads the winner's addr and data.
  - rf_wen is set to 1, except when addr == 0. A write to x0 is still accepted (ready = 1) but rf_wen stays 0.
  - No grant: rf_wen is 0, and rf_waddr/rf_wdata hold their previous values.
  - The stage never back-pressures, so one write is accepted per cycle.
- **Scoreboard** (busy[2^ADDR_WIDTH], register):
  - issue_ready = !busy[issue_addr] OR (that entry is being cleared this cycle).
  - Set busy[issue_addr] on issue_valid && issue_ready, when issue_addr != 0.
  - Clear busy[rf_waddr] in any cycle with rf_wen = 1. The bit drops at the same edge that commits the data.
  - Same-index set and clear in one cycle: set wins, and the bit stays 1.
  - busy[0] is constantly 0.
- **Queries** (combinational): qa_busy = busy[qa_addr], qb_busy = busy[qb_addr].
- **flush**:
  - Next edge: all busy bits = 0, rf_wen = 0.
  - No grants in the flush cycle: both readies are 0 and issue_ready = 0.
  - last_grant is unchanged.
- **rst**:
  - Next edge: all busy bits = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0, last_grant = 1.
  - While rst is high, all readies are 0.
  - A reset mid-operation drops any in-flight write.

## Timing
- Request to write: accepted at edge N (ready high in cycle N-1), rf_wen high in cycle N, data in the register file after edge N+1. Latency is 1 cycle from acceptance to the write strobe.
- qa_busy falls in the same cycle in which the register file read returns the new value (the cycle after rf_wen).
- issue_ready, reqN_ready and qX_busy are combinational from inputs and state; there is no combinational path from rf_* outputs back into them.
- Sustained throughput is 1 write per cycle. Two always-valid requesters alternate 0,1,0,1….

## Test plan
- Reset: assert rst for 2 cycles while req0_valid=1 -> req0_ready=0, rf_wen=0, all qX_busy=0. After release with both valid, req0 is granted first.
- Single write: issue_addr=5, then req1 writes addr=5, data=0xDEADBEEF -> qa_busy(5)=1 until rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle after req1_ready; qa_busy=0 the cycle after.
- Contention: both valid for 6 cycles with addrs 1/2 -> grants 0,1,0,1,0,1; rf_waddr sequence 1,2,1,2,1,2; never two readies at once.
- x0: issue_addr=0 then req0 writes addr=0 -> issue_ready=1, req0_ready=1, rf_wen stays 0, qa_busy(0)=0.
- Set/clear collision: busy[7]=1, commit to 7 while issue_addr=7 in the same cycle -> issue_ready=1, busy[7] remains 1. Issuing 7 while busy with no commit -> issue_ready=0.
- Flush: busy on 3, 4 and a write in flight; assert flush -> no readies that cycle; next cycle rf_wen=0 and qa_busy(3)=qb_busy(4)=0.

Source files
------------

// File: rtl/ysyx_220053_rf_wb_arbiter.sv
// ysyx_220053_rf_wb_arbiter: round-robin writeback arbiter for the 2R1W register file with a busy scoreboard
module ysyx_220053_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] qa_addr,
  input  logic [ADDR_WIDTH-1:0] qb_addr,
  output logic                  qa_busy,
  output logic                  qb_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);
  localparam int N = 1 << ADDR_WIDTH;
  logic [N-1:0]          busy_q, busy_d;
  logic                  last_q, last_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  active, g0, g1;
  assign active = !rst && !flush;
  // last_q holds the index of the requester granted most recently
  assign g0 = active && req0_valid && (!req1_valid || last_q);
  assign g1 = active && req1_valid && (!req0_valid || !last_q);
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign issue_ready = active && (!busy_q[issue_addr] || (wen_q && waddr_q == issue_addr));
  assign qa_busy = busy_q[qa_addr];
  assign qb_busy = busy_q[qb_addr];
  assign rf_wen = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign last_d = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
  assign waddr_d = g0 ? req0_addr : g1 ? req1_addr : waddr_q;
  assign wdata_d = g0 ? req0_data : g1 ? req1_data : wdata_q;
  assign wen_d = (g0 || g1) && waddr_d != '0;
  // set is applied after clear so a same-index collision leaves the bit set
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (issue_valid && issue_ready) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= flush ? '0 : busy_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_ysyx_220053_rf_wb_arbiter.sv
// tb_ysyx_220053_rf_wb_arbiter: per-cycle vector table plus a sustained-contention sequence
module tb_ysyx_220053_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst, flush, req0_valid, req1_valid, issue_valid;
  logic [4:0] req0_addr, req1_addr, issue_addr, qa_addr, qb_addr, rf_waddr;
  logic [63:0] req0_data, req1_data, rf_wdata;
  logic req0_ready, req1_ready, issue_ready, qa_busy, qb_busy, rf_wen;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ysyx_220053_rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .qa_addr(qa_addr), .qb_addr(qb_addr), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  typedef struct {
    logic rst, flush, v0;
    logic [4:0] a0;
    logic [63:0] d0;
    logic v1;
    logic [4:0] a1;
    logic [63:0] d1;
    logic iv;
    logic [4:0] ia, qa, qb;
    logic r0, r1, ir, qab, qbb, wen;
    logic [4:0] wa;
    logic [63:0] wd;
  } vec_t;
  vec_t v[24];
  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask
  initial begin
    logic el;
    logic [4:0] pa;
    v[0]  = '{1,0,1,3,'h33,0,0,0,1,3,3,0,                  0,0,0,0,0,0,0,0};
    v[1]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           1,0,1,0,0,0,0,0};
    v[2]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           0,1,1,0,0,1,1,'h1111};
    v[3]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           1,0,1,0,0,1,2,'h2222};
    v[4]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           0,1,1,0,0,1,1,'h1111};
    v[5]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           1,0,1,0,0,1,2,'h2222};
    v[6]  = '{0,0,1,1,'h1111,1,2,'h2222,0,0,1,2,           0,1,1,0,0,1,1,'h1111};
    v[7]  = '{0,0,0,0,0,0,0,0,1,5,5,2,                     0,0,1,0,0,1,2,'h2222};
    v[8]  = '{0,0,0,0,0,1,5,'hDEADBEEF,1,5,5,0,            0,1,0,1,0,0,2,'h2222};
    v[9]  = '{0,0,0,0,0,0,0,0,0,0,5,0,                     0,0,1,1,0,1,5,'hDEADBEEF};
    v[10] = '{0,0,0,0,0,0,0,0,0,0,5,0,                     0,0,1,0,0,0,5,'hDEADBEEF};
    v[11] = '{0,0,1,0,'h99,0,0,0,1,0,0,0,                  1,0,1,0,0,0,5,'hDEADBEEF};
    v[12] = '{0,0,0,0,0,0,0,0,0,0,0,0,                     0,0,1,0,0,0,0,'h99};
    v[13] = '{0,0,0,0,0,0,0,0,1,7,7,0,                     0,0,1,0,0,0,0,'h99};
    v[14] = '{0,0,1,7,'h77,0,0,0,1,7,7,0,                  1,0,0,1,0,0,0,'h99};
    v[15] = '{0,0,0,0,0,0,0,0,1,7,7,0,                     0,0,1,1,0,1,7,'h77};
    v[16] = '{0,0,0,0,0,0,0,0,0,7,7,0,                     0,0,0,1,0,0,7,'h77};
    v[17] = '{0,0,0,0,0,0,0,0,1,3,3,4,                     0,0,1,0,0,0,7,'h77};
    v[18] = '{0,0,0,0,0,1,3,'h3333,1,4,3,4,                0,1,1,1,0,0,7,'h77};
    v[19] = '{0,1,1,9,'h9,1,10,'hA,1,9,3,4,                0,0,0,1,1,1,3,'h3333};
    v[20] = '{0,0,0,0,0,0,0,0,0,0,3,4,                     0,0,1,0,0,0,3,'h3333};
    v[21] = '{0,0,1,1,'h1111,1,2,'h2222,0,0,7,0,           1,0,1,0,0,0,3,'h3333};
    v[22] = '{1,0,1,1,'h1111,1,2,'h2222,0,0,7,0,           0,0,0,0,0,1,1,'h1111};
    v[23] = '{0,0,1,1,'h1111,1,2,'h2222,0,0,0,0,           1,0,1,0,0,0,0,0};
    rst = 1; flush = 0; req0_valid = 1; req0_addr = 3; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    issue_valid = 0; issue_addr = 0; qa_addr = 0; qb_addr = 0;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst = v[i].rst; flush = v[i].flush;
      req0_valid = v[i].v0; req0_addr = v[i].a0; req0_data = v[i].d0;
      req1_valid = v[i].v1; req1_addr = v[i].a1; req1_data = v[i].d1;
      issue_valid = v[i].iv; issue_addr = v[i].ia; qa_addr = v[i].qa; qb_addr = v[i].qb;
      #1;
      chk("req0_ready", i, req0_ready, v[i].r0);
      chk("req1_ready", i, req1_ready, v[i].r1);
      chk("issue_ready", i, issue_ready, v[i].ir);
      chk("qa_busy", i, qa_busy, v[i].qab);
      chk("qb_busy", i, qb_busy, v[i].qbb);
      chk("rf_wen", i, rf_wen, v[i].wen);
      chk("rf_waddr", i, rf_waddr, v[i].wa);
      chk("rf_wdata", i, rf_wdata, v[i].wd);
    end
    el = 1'b0;
    pa = 5'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = 0; flush = 0;
      req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
      #1;
      chk("alt_req1_ready", 100 + i, req1_ready, !el);
      chk("alt_req0_ready", 100 + i, req0_ready, el);
      chk("alt_rf_waddr", 100 + i, rf_waddr, pa);
      pa = el ? 5'd1 : 5'd2;
      el = !el;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
